mtm_alu_deserializer: RTL and testbench

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_Alu_deserializer

---
 rtl/mtm_alu_deserializer.sv | 186 ++++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// -----------------------------------------------------------------------------
// mtm_alu_deserializer
//
// Receives 11-bit serial frames {start=0, type, data[7:0], stop=1}, MSB first,
// one bit per clock. Eight DATA frames build a packet of two 32-bit operands
// (B first, then A, each MSB first). A following CMD frame {x, op[2:0], crc[3:0]}
// closes the packet: the CRC-4 over {B, A, 1'b1, op} and the op code are
// checked, and either a one-cycle out_valid pulse or a one-cycle err_valid
// pulse is produced in the cycle after the CMD stop bit.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sin        in   serial input, idles high
//   out_valid  out  one-cycle pulse, a_out/b_out/op_out hold a checked operation
//   a_out      out  operand A (32 bits)
//   b_out      out  operand B (32 bits)
//   op_out     out  operation code (3 bits)
//   err_valid  out  one-cycle pulse, err_flags holds a packet error
//   err_flags  out  {ERR_DATA, ERR_CRC, ERR_OP}, one-hot while reported
// -----------------------------------------------------------------------------
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  op_out,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    // CRC-4, polynomial x^4+x+1, initial value 0, message consumed MSB first.
    function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
        logic [3:0] crc;
        logic       fb;
        crc = 4'd0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ msg[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

    // Only four of the eight op encodings name a real operation.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b101: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_e      state_q;
    logic        type_q;       // 0 = DATA frame, 1 = CMD frame
    logic [7:0]  byte_q;       // payload byte being shifted in
    logic [2:0]  bit_cnt_q;    // payload bits still to sample, 7..0
    logic [3:0]  frame_cnt_q;  // DATA frames collected in this packet, 0..8
    logic        discard_q;    // packet overflowed; drop until next CMD
    logic [63:0] shift_q;      // {B, A}; first byte ends up at [63:56]

    logic [63:0] shift_d;
    logic [3:0]  crc_calc_d;
    logic        crc_ok_d;
    logic        op_ok_d;

    // CMD-frame checks are evaluated in parallel from the collected packet and
    // the completed payload byte, so they are ready when the stop bit arrives.
    always_comb begin
        shift_d    = {shift_q[55:0], byte_q};
        crc_calc_d = crc4_calc({shift_q, 1'b1, byte_q[6:4]});
        crc_ok_d   = (crc_calc_d == byte_q[3:0]);
        op_ok_d    = op_is_legal(byte_q[6:4]);
    end

    // Frame receiver, packet assembly and registered result/error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_q      <= 1'b0;
            byte_q      <= 8'd0;
            bit_cnt_q   <= 3'd0;
            frame_cnt_q <= 4'd0;
            discard_q   <= 1'b0;
            shift_q     <= 64'd0;
            out_valid   <= 1'b0;
            err_valid   <= 1'b0;
            a_out       <= 32'd0;
            b_out       <= 32'd0;
            op_out      <= 3'd0;
            err_flags   <= 3'd0;
        end else begin
            // Pulses last a single cycle unless the stop-bit branch re-raises them.
            out_valid <= 1'b0;
            err_valid <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!sin) begin
                        state_q <= ST_TYPE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_TYPE: begin
                    type_q    <= sin;
                    bit_cnt_q <= 3'd7;
                    state_q   <= ST_DATA;
                end

                ST_DATA: begin
                    byte_q <= {byte_q[6:0], sin};
                    if (bit_cnt_q == 3'd0) begin
                        state_q <= ST_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                    end
                end

                ST_STOP: begin
                    state_q <= ST_IDLE;
                    if (!sin) begin
                        // Framing error: drop the whole packet in progress.
                        err_valid   <= 1'b1;
                        err_flags   <= ERR_DATA;
                        frame_cnt_q <= 4'd0;
                        discard_q   <= 1'b0;
                    end else if (!type_q) begin
                        if (discard_q) begin
                            frame_cnt_q <= 4'd0;
                        end else if (frame_cnt_q == 4'd8) begin
                            // Ninth DATA frame: report once, then swallow the rest.
                            err_valid   <= 1'b1;
                            err_flags   <= ERR_DATA;
                            frame_cnt_q <= 4'd0;
                            discard_q   <= 1'b1;
                        end else begin
                            shift_q     <= shift_d;
                            frame_cnt_q <= frame_cnt_q + 4'd1;
                        end
                    end else begin
                        frame_cnt_q <= 4'd0;
                        discard_q   <= 1'b0;
                        if (discard_q) begin
                            // CMD closing an overflowed packet is dropped silently.
                            err_valid <= 1'b0;
                        end else if (frame_cnt_q != 4'd8) begin
                            err_valid <= 1'b1;
                            err_flags <= ERR_DATA;
                        end else if (!crc_ok_d) begin
                            err_valid <= 1'b1;
                            err_flags <= ERR_CRC;
                        end else if (!op_ok_d) begin
                            err_valid <= 1'b1;
                            err_flags <= ERR_OP;
                        end else begin
                            out_valid <= 1'b1;
                            a_out     <= shift_q[31:0];
                            b_out     <= shift_q[63:32];
                            op_out    <= byte_q[6:4];
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// -----------------------------------------------------------------------------
// tb_mtm_alu_deserializer
//
// Table of complete packets (operands, op, crc, expected outcome) sent
// back-to-back, followed by hand-written sequences for count errors, packet
// overflow/discard, framing errors and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_mtm_alu_deserializer;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic        out_valid;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic        err_valid;
    logic [2:0]  err_flags;

    int total;
    int bad;
    int ov_cnt;
    int ev_cnt;
    int both_cnt;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_valid (out_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_out    (op_out),
        .err_valid (err_valid),
        .err_flags (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled just after each rising edge.
    initial begin
        ov_cnt   = 0;
        ev_cnt   = 0;
        both_cnt = 0;
    end
    always @(posedge clk) begin
        #1;
        if (out_valid) ov_cnt++;
        if (err_valid) ev_cnt++;
        if (out_valid && err_valid) both_cnt++;
    end

    typedef struct {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic        cmd_b7;
        logic        exp_out;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_op;
    logic [2:0]  exp_fl;

    // Reference CRC as polynomial long division of {msg, 4'b0} by 10011.
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
        logic [71:0] v;
        v = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        end
        return v[3:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame starting at a falling edge; returns at the falling edge
    // after the stop bit was sampled, i.e. inside the pulse cycle.
    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop_bit);
        logic [10:0] f;
        f = {1'b0, typ, d, stop_bit};
        for (int i = 10; i >= 0; i--) begin
            sin = f[i];
            @(negedge clk);
        end
        sin = 1'b1;
    endtask

    task automatic send_data_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_frame(1'b0, w[i*8 +: 8], 1'b1);
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input logic [3:0] crc, input logic b7);
        send_data_word(b);
        send_data_word(a);
        send_frame(1'b1, {b7, op, crc}, 1'b1);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".a_out"},     64'(a_out),     64'(exp_a));
        check({tag, ".b_out"},     64'(b_out),     64'(exp_b));
        check({tag, ".op_out"},    64'(op_out),    64'(exp_op));
        check({tag, ".err_flags"}, 64'(err_flags), 64'(exp_fl));
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ov0;
        int ev0;
        total = 0;
        bad   = 0;
        sin   = 1'b1;
        rst_n = 1'b0;
        exp_a = 32'd0; exp_b = 32'd0; exp_op = 3'd0; exp_fl = 3'd0;

        // Hand-computed CRCs: 0xE for B=2222.., A=1111.., op=100; 0xB for all-zero op=000.
        vecs[0] = '{32'h22222222, 32'h11111111, 3'b100, 4'hE, 1'b0, 1'b1, 3'b000};
        vecs[1] = '{32'h22222222, 32'h11111111, 3'b100, 4'h0, 1'b0, 1'b0, 3'b010};
        vecs[2] = '{32'h22222222, 32'h11111111, 3'b010, 4'h4, 1'b0, 1'b0, 3'b001};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101,
                    ref_crc(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101), 1'b0, 1'b1, 3'b000};
        vecs[4] = '{32'h00000000, 32'h00000000, 3'b000, 4'hB, 1'b0, 1'b1, 3'b000};
        vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 3'b001,
                    ref_crc(32'h12345678, 32'h9ABCDEF0, 3'b001), 1'b1, 1'b1, 3'b000};
        vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 3'b011,
                    ref_crc(32'h12345678, 32'h9ABCDEF0, 3'b011), 1'b0, 1'b0, 3'b001};
        vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 3'b001,
                    ref_crc(32'h12345678, 32'h9ABCDEF0, 3'b001) ^ 4'h1, 1'b0, 1'b0, 3'b010};
        vecs[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 3'b110,
                    ref_crc(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b110) ^ 4'h8, 1'b0, 1'b0, 3'b010};
        vecs[9] = '{32'h80000001, 32'h7FFFFFFE, 3'b111,
                    ref_crc(32'h80000001, 32'h7FFFFFFE, 3'b111), 1'b0, 1'b0, 3'b001};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.err_valid", 64'(err_valid), 64'd0);
        check_outputs("rst");
        rst_n = 1'b1;
        idle(2);

        // Table: all packets back-to-back.
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            ov0 = ov_cnt;
            ev0 = ev_cnt;
            send_packet(vecs[i].b, vecs[i].a, vecs[i].op, vecs[i].crc, vecs[i].cmd_b7);
            if (vecs[i].exp_out) begin
                exp_a = vecs[i].a; exp_b = vecs[i].b; exp_op = vecs[i].op;
            end else begin
                exp_fl = vecs[i].exp_flags;
            end
            check({tag, ".out_valid"}, 64'(out_valid), 64'(vecs[i].exp_out));
            check({tag, ".err_valid"}, 64'(err_valid), 64'(!vecs[i].exp_out));
            check({tag, ".pulses"}, 64'((ov_cnt - ov0) + (ev_cnt - ev0)), 64'd1);
            check_outputs(tag);
        end
        idle(3);

        // 7 DATA frames then CMD: data count error.
        ov0 = ov_cnt; ev0 = ev_cnt;
        send_data_word(32'hCAFEBABE);
        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h33, 1'b1);
        send_frame(1'b1, {1'b0, 3'b000, 4'h0}, 1'b1);
        exp_fl = 3'b100;
        check("short.err_valid", 64'(err_valid), 64'd1);
        check("short.out_valid", 64'(out_valid), 64'd0);
        check("short.pulses", 64'((ov_cnt - ov0) + (ev_cnt - ev0)), 64'd1);
        check_outputs("short");

        // 9 DATA frames: error at the 9th stop, then discard until CMD.
        ov0 = ov_cnt; ev0 = ev_cnt;
        send_data_word(32'h22222222);
        send_data_word(32'h11111111);
        check("ovf.no_early", 64'((ov_cnt - ov0) + (ev_cnt - ev0)), 64'd0);
        send_frame(1'b0, 8'h44, 1'b1);
        check("ovf.err_valid", 64'(err_valid), 64'd1);
        check("ovf.err_flags", 64'(err_flags), 64'd4);
        ov0 = ov_cnt; ev0 = ev_cnt;
        send_frame(1'b0, 8'h55, 1'b1);
        send_frame(1'b0, 8'h66, 1'b1);
        send_frame(1'b1, {1'b0, 3'b100, 4'hE}, 1'b1);
        idle(2);
        check("ovf.silent", 64'((ov_cnt - ov0) + (ev_cnt - ev0)), 64'd0);
        exp_fl = 3'b100;
        check_outputs("ovf");
        send_packet(32'h22222222, 32'h11111111, 3'b100, 4'hE, 1'b0);
        exp_a = 32'h11111111; exp_b = 32'h22222222; exp_op = 3'b100;
        check("ovf.recover", 64'(out_valid), 64'd1);
        check_outputs("ovf.recover");

        // Framing error mid-packet, then a clean packet.
        ov0 = ov_cnt; ev0 = ev_cnt;
        send_frame(1'b0, 8'h01, 1'b1);
        send_frame(1'b0, 8'h02, 1'b1);
        send_frame(1'b0, 8'h03, 1'b0);
        check("frm.err_valid", 64'(err_valid), 64'd1);
        check("frm.err_flags", 64'(err_flags), 64'd4);
        send_packet(32'h00000000, 32'h00000000, 3'b000, 4'hB, 1'b0);
        exp_a = 32'd0; exp_b = 32'd0; exp_op = 3'b000; exp_fl = 3'b100;
        check("frm.recover", 64'(out_valid), 64'd1);
        check("frm.pulses", 64'((ov_cnt - ov0) + (ev_cnt - ev0)), 64'd2);
        check_outputs("frm.recover");

        // Reset during the 5th DATA frame, then a full valid packet.
        send_data_word(32'hDEADBEEF);
        sin = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid.rst_a", 64'(a_out), 64'd0);
        check("mid.rst_flags", 64'(err_flags), 64'd0);
        sin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        ov0 = ov_cnt; ev0 = ev_cnt;
        send_packet(32'h22222222, 32'h11111111, 3'b100, 4'hE, 1'b0);
        idle(3);
        exp_a = 32'h11111111; exp_b = 32'h22222222; exp_op = 3'b100; exp_fl = 3'b000;
        check("mid.ov_pulses", 64'(ov_cnt - ov0), 64'd1);
        check("mid.ev_pulses", 64'(ev_cnt - ev0), 64'd0);
        check_outputs("mid");

        check("never_both", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
